// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: key codes, FSM states,
// operators and display sources.
package calc_pkg;

   localparam logic [3:0] TECLA_SUMA   = 4'hA;
   localparam logic [3:0] TECLA_RESTA  = 4'hB;
   localparam logic [3:0] TECLA_MULT   = 4'hC;
   localparam logic [3:0] TECLA_DIV    = 4'hD;
   localparam logic [3:0] TECLA_IGUAL  = 4'hE;
   localparam logic [3:0] TECLA_BORRAR = 4'hF;

   typedef enum logic [2:0] {
      EST_NUM1      = 3'b000,
      EST_NUM2      = 3'b001,
      EST_CALCULAR  = 3'b010,
      EST_RESULTADO = 3'b011,
      EST_ERROR     = 3'b100
   } estado_t;

   typedef enum logic [1:0] {
      OP_SUMA  = 2'b00,
      OP_RESTA = 2'b01,
      OP_MULT  = 2'b10,
      OP_DIV   = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      MOSTRAR_OP1 = 2'b00,
      MOSTRAR_OP2 = 2'b01,
      MOSTRAR_RES = 2'b10,
      MOSTRAR_ERR = 2'b11
   } mostrar_t;

   // The operand being computed keeps showing while the ALU works.
   function automatic mostrar_t mostrar_de(input estado_t e);
      case (e)
         EST_NUM1:               return MOSTRAR_OP1;
         EST_NUM2, EST_CALCULAR: return MOSTRAR_OP2;
         EST_RESULTADO:          return MOSTRAR_RES;
         EST_ERROR:              return MOSTRAR_ERR;
         default:                return MOSTRAR_OP1;
      endcase
   endfunction

endpackage

// File: rtl/decodificador_tecla.sv
// Classifies a keypad code into digit / operator / equals / clear and
// maps operator keys onto the ALU operator encoding.
module decodificador_tecla
   import calc_pkg::*;
(
   input  logic [3:0] tecla,
   output logic       es_digito,
   output logic       es_operador,
   output logic       es_igual,
   output logic       es_borrar,
   output logic [1:0] op
);

   assign es_digito   = (tecla <= 4'd9);
   assign es_operador = (tecla >= TECLA_SUMA) && (tecla <= TECLA_DIV);
   assign es_igual    = (tecla == TECLA_IGUAL);
   assign es_borrar   = (tecla == TECLA_BORRAR);

   always_comb begin
      case (tecla)
         TECLA_SUMA:  op = OP_SUMA;
         TECLA_RESTA: op = OP_RESTA;
         TECLA_MULT:  op = OP_MULT;
         TECLA_DIV:   op = OP_DIV;
         default:     op = OP_SUMA;
      endcase
   end

endmodule

// File: rtl/control_calculadora.sv
// Top-level sequencer of the 4-digit calculator: keypad events in, operand
// load strobes, ALU handshake and display selection out.
module control_calculadora
   import calc_pkg::*;
#(
   parameter int MAX_DIGITOS    = 4,
   parameter int TIMEOUT_CICLOS = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tecla_valida,
   input  logic [3:0] tecla,
   input  logic       alu_done,
   input  logic       alu_error,
   output logic       num1_en,
   output logic       num2_en,
   output logic [3:0] digito,
   output logic [1:0] operacion,
   output logic       alu_start,
   output logic       cargar_resultado,
   output logic       borrar,
   output logic [1:0] mostrar_sel,
   output logic [2:0] contador,
   output logic [2:0] estado
);

   localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITOS);
   localparam logic [7:0] WD_LIM  = 8'(TIMEOUT_CICLOS);

   logic       es_digito, es_operador, es_igual, es_borrar;
   logic [1:0] op;

   decodificador_tecla u_decodificador (
      .tecla       (tecla),
      .es_digito   (es_digito),
      .es_operador (es_operador),
      .es_igual    (es_igual),
      .es_borrar   (es_borrar),
      .op          (op)
   );

   estado_t    estado_q, estado_n;
   logic [7:0] watchdog, watchdog_n, wd_inc;
   logic [2:0] contador_n;
   logic [3:0] digito_n;
   logic [1:0] operacion_n;
   logic       num1_en_n, num2_en_n, alu_start_n, cargar_n, borrar_n;
   logic       k_dig, k_op, k_igual, k_borrar;

   assign k_dig    = tecla_valida && es_digito;
   assign k_op     = tecla_valida && es_operador;
   assign k_igual  = tecla_valida && es_igual;
   assign k_borrar = tecla_valida && es_borrar;
   assign wd_inc   = watchdog + 8'd1;

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      estado_n    = estado_q;
      contador_n  = contador;
      digito_n    = digito;
      operacion_n = operacion;
      watchdog_n  = 8'd0;
      num1_en_n   = 1'b0;
      num2_en_n   = 1'b0;
      alu_start_n = 1'b0;
      cargar_n    = 1'b0;
      borrar_n    = 1'b0;

      case (estado_q)
         EST_NUM1: begin
            if (k_dig) begin
               if (contador < MAX_CNT) begin
                  num1_en_n  = 1'b1;
                  digito_n   = tecla;
                  contador_n = contador + 3'd1;
               end
            end else if (k_op) begin
               if (contador != 3'd0) begin
                  operacion_n = op;
                  contador_n  = 3'd0;
                  estado_n    = EST_NUM2;
               end
            end else if (k_borrar) begin
               borrar_n   = 1'b1;
               contador_n = 3'd0;
            end
         end

         EST_NUM2: begin
            if (k_dig) begin
               if (contador < MAX_CNT) begin
                  num2_en_n  = 1'b1;
                  digito_n   = tecla;
                  contador_n = contador + 3'd1;
               end
            end else if (k_op) begin
               if (contador == 3'd0) operacion_n = op;
            end else if (k_igual) begin
               if (contador != 3'd0) begin
                  alu_start_n = 1'b1;
                  contador_n  = 3'd0;
                  estado_n    = EST_CALCULAR;
               end
            end else if (k_borrar) begin
               borrar_n   = 1'b1;
               contador_n = 3'd0;
               estado_n   = EST_NUM1;
            end
         end

         EST_CALCULAR: begin
            // Clear outranks a simultaneous alu_done, which outranks the timeout.
            if (k_borrar) begin
               borrar_n = 1'b1;
               estado_n = EST_NUM1;
            end else if (alu_done) begin
               estado_n = alu_error ? EST_ERROR : EST_RESULTADO;
            end else if (wd_inc == WD_LIM) begin
               estado_n = EST_ERROR;
            end else begin
               watchdog_n = wd_inc;
            end
            contador_n = 3'd0;
         end

         EST_RESULTADO: begin
            if (k_op) begin
               cargar_n    = 1'b1;
               operacion_n = op;
               contador_n  = 3'd0;
               estado_n    = EST_NUM2;
            end else if (k_dig || k_borrar) begin
               borrar_n   = 1'b1;
               contador_n = 3'd0;
               estado_n   = EST_NUM1;
            end
         end

         EST_ERROR: begin
            if (k_borrar) begin
               borrar_n   = 1'b1;
               contador_n = 3'd0;
               estado_n   = EST_NUM1;
            end
         end

         default: begin
            contador_n = 3'd0;
            estado_n   = EST_NUM1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q         <= EST_NUM1;
         watchdog         <= 8'd0;
         contador         <= 3'd0;
         digito           <= 4'd0;
         operacion        <= 2'b00;
         num1_en          <= 1'b0;
         num2_en          <= 1'b0;
         alu_start        <= 1'b0;
         cargar_resultado <= 1'b0;
         borrar           <= 1'b0;
         mostrar_sel      <= 2'b00;
      end else begin
         estado_q         <= estado_n;
         watchdog         <= watchdog_n;
         contador         <= contador_n;
         digito           <= digito_n;
         operacion        <= operacion_n;
         num1_en          <= num1_en_n;
         num2_en          <= num2_en_n;
         alu_start        <= alu_start_n;
         cargar_resultado <= cargar_n;
         borrar           <= borrar_n;
         mostrar_sel      <= mostrar_de(estado_n);
      end
   end

   assign estado = estado_q;

endmodule

// File: tb/tb_control_calculadora.sv
// Self-checking bench: directed scenarios plus random key/ALU traffic, all
// compared every cycle against an operand-queue model of the calculator.
module tb_control_calculadora;

   localparam int MAXD = 4;
   localparam int TMO  = 255;
   localparam int P_NUM1 = 0, P_NUM2 = 1, P_CALC = 2, P_RES = 3, P_ERR = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tecla_valida = 1'b0;
   logic [3:0] tecla = 4'd0;
   logic       alu_done = 1'b0;
   logic       alu_error = 1'b0;
   logic       num1_en, num2_en, alu_start, cargar_resultado, borrar;
   logic [3:0] digito;
   logic [1:0] operacion, mostrar_sel;
   logic [2:0] contador, estado;

   control_calculadora #(.MAX_DIGITOS(MAXD), .TIMEOUT_CICLOS(TMO)) dut (
      .clk              (clk),
      .reset            (reset),
      .tecla_valida     (tecla_valida),
      .tecla            (tecla),
      .alu_done         (alu_done),
      .alu_error        (alu_error),
      .num1_en          (num1_en),
      .num2_en          (num2_en),
      .digito           (digito),
      .operacion        (operacion),
      .alu_start        (alu_start),
      .cargar_resultado (cargar_resultado),
      .borrar           (borrar),
      .mostrar_sel      (mostrar_sel),
      .contador         (contador),
      .estado           (estado)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n1_pulses = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the two operands are digit queues, contador is the
   // length of the queue being typed, and the ALU wait is a cycle count.
   int         m_phase;
   logic [3:0] q1[$];
   logic [3:0] q2[$];
   int         m_oper;
   int         m_wait;
   bit         e_n1, e_n2, e_start, e_cargar, e_borrar;
   int         e_digito;

   task automatic model_reset();
      m_phase = P_NUM1;
      q1.delete();
      q2.delete();
      m_oper = 0;
      m_wait = 0;
      {e_n1, e_n2, e_start, e_cargar, e_borrar} = '0;
      e_digito = 0;
   endtask

   task automatic clear_all(input int next_phase);
      e_borrar = 1;
      q1.delete();
      q2.delete();
      m_phase = next_phase;
   endtask

   task automatic model_step(input bit v, input int k, input bit done, input bit err);
      bit is_dig, is_op, is_eq, is_clr;
      is_dig = v && (k <= 9);
      is_op  = v && (k >= 10) && (k <= 13);
      is_eq  = v && (k == 14);
      is_clr = v && (k == 15);
      {e_n1, e_n2, e_start, e_cargar, e_borrar} = '0;
      case (m_phase)
         P_NUM1: begin
            if (is_dig && q1.size() < MAXD) begin
               q1.push_back(4'(k)); e_n1 = 1; e_digito = k;
            end else if (is_op && q1.size() > 0) begin
               m_oper = k - 10; q2.delete(); m_phase = P_NUM2;
            end else if (is_clr) clear_all(P_NUM1);
         end
         P_NUM2: begin
            if (is_dig && q2.size() < MAXD) begin
               q2.push_back(4'(k)); e_n2 = 1; e_digito = k;
            end else if (is_op && q2.size() == 0) begin
               m_oper = k - 10;
            end else if (is_eq && q2.size() > 0) begin
               e_start = 1; m_wait = 0; m_phase = P_CALC;
            end else if (is_clr) clear_all(P_NUM1);
         end
         P_CALC: begin
            m_wait++;
            if (is_clr) clear_all(P_NUM1);
            else if (done) m_phase = err ? P_ERR : P_RES;
            else if (m_wait >= TMO) m_phase = P_ERR;
         end
         P_RES: begin
            if (is_op) begin
               e_cargar = 1; m_oper = k - 10; q2.delete(); m_phase = P_NUM2;
            end else if (is_dig || is_clr) clear_all(P_NUM1);
         end
         default: if (is_clr) clear_all(P_NUM1);
      endcase
   endtask

   function automatic int exp_contador();
      if (m_phase == P_NUM1) return q1.size();
      if (m_phase == P_NUM2) return q2.size();
      return 0;
   endfunction

   function automatic int exp_mostrar();
      case (m_phase)
         P_NUM1:         return 0;
         P_NUM2, P_CALC: return 1;
         P_RES:          return 2;
         default:        return 3;
      endcase
   endfunction

   task automatic compare_all();
      if (num1_en === 1'b1) n1_pulses++;
      check("num1_en", 8'(num1_en), 8'(e_n1));
      check("num2_en", 8'(num2_en), 8'(e_n2));
      if (e_n1 || e_n2) check("digito", 8'(digito), 8'(e_digito));
      check("operacion", 8'(operacion), 8'(m_oper));
      check("alu_start", 8'(alu_start), 8'(e_start));
      check("cargar_resultado", 8'(cargar_resultado), 8'(e_cargar));
      check("borrar", 8'(borrar), 8'(e_borrar));
      check("mostrar_sel", 8'(mostrar_sel), 8'(exp_mostrar()));
      check("contador", 8'(contador), 8'(exp_contador()));
      check("estado", 8'(estado), 8'(m_phase));
   endtask

   // Called at a falling edge; drives one cycle and checks after the next rising edge.
   task automatic step(input bit v, input int k, input bit d, input bit e);
      tecla_valida = v;
      tecla        = 4'(k);
      alu_done     = d;
      alu_error    = e;
      @(posedge clk);
      model_step(v, k, d, e);
      @(negedge clk);
      compare_all();
      tecla_valida = 1'b0;
      alu_done     = 1'b0;
      alu_error    = 1'b0;
   endtask

   task automatic key(input int k);
      step(1'b1, k, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pulses"}, 8'({num1_en, num2_en, alu_start, cargar_resultado, borrar}), 8'd0);
      check({tag, "_digito"}, 8'(digito), 8'd0);
      check({tag, "_operacion"}, 8'(operacion), 8'd0);
      check({tag, "_mostrar"}, 8'(mostrar_sel), 8'd0);
      check({tag, "_contador"}, 8'(contador), 8'd0);
      check({tag, "_estado"}, 8'(estado), 8'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b1;

      // Basic chain 12 + 3 =
      key(1); key(2); key(4'hA); key(3); key(4'hE);
      idle(2);
      step(1'b0, 0, 1'b1, 1'b0);
      check("t1_estado_res", 8'(estado), 8'd3);
      check("t1_mostrar_res", 8'(mostrar_sel), 8'd2);

      // Digit saturation in NUM1
      key(4'hF);
      n1_pulses = 0;
      key(1); key(2); key(3); key(4); key(5);
      check("t2_num1_pulses", 8'(n1_pulses), 8'd4);
      check("t2_contador", 8'(contador), 8'd4);

      // Division ending in an ALU error
      key(4'hF);
      key(7); key(4'hD); key(0); key(4'hE);
      step(1'b0, 0, 1'b1, 1'b1);
      check("t3_estado_err", 8'(estado), 8'd4);
      key(5);
      check("t3_err_holds", 8'(estado), 8'd4);
      key(4'hF);
      check("t3_estado_num1", 8'(estado), 8'd0);

      // Watchdog expiry
      key(1); key(4'hA); key(2); key(4'hE);
      idle(TMO - 1);
      check("t4_still_calc", 8'(estado), 8'd2);
      idle(1);
      check("t4_timeout_err", 8'(estado), 8'd4);
      key(4'hF);

      // Clear colliding with alu_done, then chaining from RESULTADO
      key(1); key(4'hA); key(2); key(4'hE);
      step(1'b1, 4'hF, 1'b1, 1'b0);
      check("t5_clear_wins", 8'(estado), 8'd0);
      key(1); key(4'hA); key(2); key(4'hE);
      step(1'b0, 0, 1'b1, 1'b0);
      key(4'hB);
      check("t5_cargar", 8'(cargar_resultado), 8'd1);
      check("t5_operacion", 8'(operacion), 8'd1);

      // Asynchronous reset mid-CALCULAR
      key(3); key(4'hE);
      check("t6_in_calc", 8'(estado), 8'd2);
      #2 reset = 1'b0;
      #1 check_outputs_zero("async_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      step(1'b0, 0, 1'b1, 1'b0);
      check("t6_done_ignored", 8'(estado), 8'd0);

      // Random traffic, biased towards digits and with sporadic ALU answers
      for (int i = 0; i < 1500; i++) begin
         int  r;
         int  k;
         bit  v;
         r = int'($urandom_range(0, 99));
         v = (r < 70);
         if (r < 35) k = int'($urandom_range(0, 9));
         else if (r < 55) k = int'($urandom_range(10, 13));
         else if (r < 66) k = 14;
         else if (r < 69) k = 15;
         else k = int'($urandom_range(0, 15));
         step(v, k, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
